// File: rtl/fullass_serial.sv
// Word-serial multi-precision adder/subtractor: one WIDTH-bit ripple chain
// processes the operands least-significant word first, carrying between words in a flop.

module fullass_chain #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry_out = c[WIDTH];
  end
endmodule

module fullass_serial #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic                   carry_in,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out
);
  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // state is kept as a plainly named signal so checkers can bind to it
  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           sub_q;
  logic           carry_q;
  logic [IW-1:0]  idx;

  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] chain_sum;
  logic             chain_co;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        a_word = a_q[i*WIDTH +: WIDTH];
        b_word = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // subtract is a + ~b + 1; the +1 comes from the carry seed set at start
  assign b_eff = sub_q ? ~b_word : b_word;

  fullass_chain #(.WIDTH(WIDTH)) u_chain (
    .a         (a_word),
    .b         (b_eff),
    .carry_in  (carry_q),
    .sum       (chain_sum),
    .carry_out (chain_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            sub_q     <= sub;
            carry_q   <= sub ? 1'b1 : carry_in;
            idx       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) sum[i*WIDTH +: WIDTH] <= chain_sum;
          end
          carry_q <= chain_co;
          if (idx == LAST) begin
            carry_out <= chain_co;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fullass_serial.sv
// Bench for fullass_serial (WIDTH=8, WORDS=4): directed operations with hand-computed
// results pushed to a scoreboard queue; a monitor pops and compares on every done pulse.

module tb_fullass_serial;
  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;
  localparam int W     = N + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         carry_in;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry_out;

  fullass_serial #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           last_done_cyc = -1;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: done is the only point where a result is valid.
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W-1:0] e;
      int ec;
      last_done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got sum=%h carry_out=%b want no done (cyc %0d)", sum, carry_out, cyc);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        if ({carry_out, sum} !== e) begin
          errors++;
          $display("FAIL result got co=%b sum=%h want co=%b sum=%h", carry_out, sum, e[N], e[N-1:0]);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, ec);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // The done pulse is visible WORDS counter ticks after the accepting edge.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts,
                       input logic tc, input bit expect_done, input logic [W-1:0] exp);
    @(negedge clk);
    a = ta; b = tb; sub = ts; carry_in = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc + WORDS);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got busy=%b pending=%0d want idle within %0d cycles", busy, exp_q.size(), budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_done;
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", N'(busy), '0);
    check("reset_done", N'(done), '0);
    check("reset_sum", sum, '0);
    check("reset_carry_out", N'(carry_out), '0);

    // plain add and full-width wrap
    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, {1'b0, 32'h00000100});
    wait_idle(20);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, {1'b1, 32'h00000000});
    wait_idle(20);
    issue(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, {1'b1, 32'h00000000});
    wait_idle(20);
    // subtract with and without borrow; carry_in ignored for subtract
    issue(32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b1, {1'b0, 32'hFFFFFFFE});
    wait_idle(20);
    issue(32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b1, {1'b1, 32'h00000002});
    wait_idle(20);
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, {1'b1, 32'h4B4B4B4B});
    wait_idle(20);

    // busy lockout: a second start during RUN is dropped
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, {1'b0, 32'h00000002});
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("lockout_busy_c%0d", i), N'(busy), (i <= 5) ? N'(1) : N'(0));
      if (i == 2) begin
        a = 32'h9; b = 32'h9; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
      end
      if (i == 3) start = 1'b0;
    end
    repeat (8) @(negedge clk);
    wait_idle(20);

    // reset in the middle of an operation discards it
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", N'(busy), '0);
    check("midrst_done", N'(done), '0);
    check("midrst_sum", sum, '0);
    check("midrst_carry_out", N'(carry_out), '0);
    repeat (8) @(negedge clk);
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, {1'b0, 32'h23456789});
    wait_idle(20);

    // back-to-back: restart in the cycle after done
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, {1'b0, 32'h00010000});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    first_done = cyc;
    @(negedge clk);
    check("b2b_sum_held", sum, 32'h00010000);
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; sub = 1'b0; carry_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({1'b1, 32'h00000000});
    cyc_q.push_back(cyc + WORDS);
    @(negedge clk);
    check("b2b_sum_cleared", sum, '0);
    wait_idle(20);
    check("b2b_done_spacing", N'(last_done_cyc - first_done), N'(6));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", N'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fullass_serial.md
# fullass_serial

Multi-precision sequential adder/subtractor built around a single `WIDTH`-bit `fullass_chain` instance. It adds or subtracts two `WIDTH*WORDS`-bit operands one word per cycle, least-significant word first, holding the inter-word carry in a flop. It trades `WORDS` cycles of latency for one narrow ripple chain, and is the shared wide-arithmetic engine for blocks that cannot afford a full-width chain.

## Interface

Parameters:
- `WIDTH`, default 8: word width of the internal `fullass_chain`; must be ≥ 2.
- `WORDS`, default 4: number of words per operand; must be ≥ 1.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `start`  input  1: request a new operation; sampled only in IDLE.
- `sub`  input  1: 0 = add, 1 = subtract (a − b); latched with `start`.
- `carry_in`  input  1: carry seed for add; ignored when `sub`=1.
- `a`  input  WIDTH*WORDS: operand A; latched with `start`.
- `b`  input  WIDTH*WORDS: operand B; latched with `start`.
- `busy`  output  1: high in RUN and DONE.
- `done`  output  1: single-cycle pulse; result valid.
- `sum`  output  WIDTH*WORDS: registered result; held until the next accepted `start`.
- `carry_out`  output  1: final carry; for subtract, 1 = no borrow (a ≥ b unsigned).

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE, `start`=1:
  - Latch `a` and `b` into operand registers; latch `sub`.
  - Word index ← 0.
  - Carry flop ← (`sub` ? 1 : `carry_in`).
  - Clear `sum` and `carry_out` to 0.
  - Go to RUN.
- IDLE, `start`=0: stay; outputs hold.
- RUN, each cycle at index k:
  - Chain inputs: `a` word k, (`sub` ? ~`b` word k : `b` word k), and the carry flop.
  - Write the chain sum into `sum[k*WIDTH +: WIDTH]`.
  - Carry flop ← chain carry_out.
  - If k = WORDS−1: `carry_out` ← chain carry_out; go to DONE. Otherwise k ← k+1.
- DONE: assert `done` for exactly one cycle; go to IDLE.
- `start` during RUN or DONE is ignored and is not queued. Operand inputs may change freely after acceptance.
- Arithmetic is modulo 2^(WIDTH*WORDS); no overflow flag. Signed overflow is left to the consumer.
- Index counter width is clog2(WORDS), minimum 1 bit. With `WORDS`=1, RUN lasts one cycle.
- Reset, asserted in any state including mid-RUN:
  - Next state IDLE.
  - `sum`, `carry_out`, `done`, `busy`, index, and carry flop all go to 0.
  - The partial result is discarded.

## Timing

- `start` accepted at edge t.
- RUN occupies cycles t+1 … t+WORDS.
- `done`=1 and the final `sum`/`carry_out` are visible in cycle t+WORDS+1.
- Latency from the accepting edge to `done`: WORDS+1 cycles.
- Back-to-back operation: earliest next accepted `start` is the cycle after `done`. Throughput is one operation per WORDS+2 cycles.
- `busy` rises the cycle after acceptance and falls the cycle after `done`.
- Partial `sum` words update during RUN. Consumers must sample only on `done` or while idle.
- Reset values of all outputs: 0.
- The chain is combinational between the operand and carry registers and the `sum` register. The critical path is WIDTH full-adder stages.

## Test plan

(WIDTH=8, WORDS=4)

- Add, carry across words: a=0x000000FF, b=0x00000001, sub=0, carry_in=0, start at t → `done` at t+5, sum=0x00000100, carry_out=0.
- Full-width wrap: a=0xFFFFFFFF, b=0x00000001, carry_in=0 → sum=0x00000000, carry_out=1. Repeat with b=0 and carry_in=1 → same result.
- Subtract with borrow: a=5, b=7, sub=1 → sum=0xFFFFFFFE, carry_out=0. Subtract without borrow: a=7, b=5, sub=1, carry_in=1 (ignored) → sum=0x00000002, carry_out=1.
- Busy lockout:
  - Pulse `start` with a=1, b=1 at t.
  - Pulse `start` again at t+2 with a=9, b=9.
  - Expect one `done` at t+5, sum=2, and no second `done`.
  - `busy` is high for t+1…t+5.
- Reset mid-op: start a=0x12345678, b=0x11111111. Assert `rst` for one cycle at t+2 → `busy`, `done`, `sum`, and `carry_out` are 0 from t+3 and no `done` follows. A fresh start then yields 0x23456789 at 5 cycles latency.
- Back-to-back: restart in the cycle after `done` → second `done` exactly 6 cycles after the first. The first `sum` is held until the second acceptance, then cleared.
